instr_encoder: RTL

- Encoder counterpart to the control decoder. Takes decoded instruction fields (operation, register indices, immediate) on a valid/ready stream and packs them into 32-bit RV32I words.
- Supports only the ops the decoder handles: lw, sw, add, sub, slt, or, and, beq.
- Words are buffered in a FIFO and streamed out with a sequential byte address, for loading instruction memory from a self-test generator or program loader.
- Illegal field combinations are consumed, dropped and counted.

---
 rtl/instr_encoder_if.sv | 30 +++
 rtl/instr_encoder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/instr_encoder_if.sv
// Field-set input stream, encoded-word output stream and error status for instr_encoder.
// The slave modport is the encoder's view; master is the program loader / generator side.
interface instr_encoder_if #(
  parameter int unsigned AW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [12:0]   in_imm;
  logic          addr_clr;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          err;
  logic [7:0]    err_count;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, addr_clr, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err, err_count
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, addr_clr, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded fields (lw/sw/add/sub/slt/or/and/beq) into RV32I words, buffers them in a
// FIFO and streams them out with a running byte address; illegal field sets are dropped.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AW        = 32,
  parameter int unsigned BASE_ADDR = 0
) (
  input logic            clk,
  input logic            rst_n,
  instr_encoder_if.slave bus
);
  localparam int unsigned   PW   = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);
  localparam logic [AW-1:0] STEP = AW'(4);

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_SW  = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_SLT = 3'd4,
    OP_OR  = 3'd5,
    OP_AND = 3'd6,
    OP_BEQ = 3'd7
  } op_e;

  // Loads/stores need a 12-bit signed offset; branches need an even offset.
  function automatic logic is_legal(input logic [2:0] op, input logic [12:0] imm);
    logic ok;
    ok = 1'b1;
    case (op_e'(op))
      OP_LW, OP_SW: ok = (imm[12] == imm[11]);
      OP_BEQ:       ok = ~imm[0];
      default:      ok = 1'b1;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] encode(input logic [2:0]  op,
                                         input logic [4:0]  rd,
                                         input logic [4:0]  rs1,
                                         input logic [4:0]  rs2,
                                         input logic [12:0] imm);
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] word;
    f7 = 7'b0000000;
    f3 = 3'b000;
    case (op_e'(op))
      OP_SUB:  f7 = 7'b0100000;
      OP_SLT:  f3 = 3'b010;
      OP_OR:   f3 = 3'b110;
      OP_AND:  f3 = 3'b111;
      default: ;
    endcase
    case (op_e'(op))
      OP_LW:   word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      OP_SW:   word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      OP_BEQ:  word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      default: word = {f7, rs2, rs1, f3, rd, 7'b0110011};
    endcase
    return word;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          err_q, err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic full, empty, accept, legal, push, drop, pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                  (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign empty  = (wr_ptr_q == rd_ptr_q);

  assign bus.in_ready = rst_n && !full;
  assign accept = bus.in_valid && bus.in_ready;
  assign legal  = is_legal(bus.in_op, bus.in_imm);
  assign push   = accept && legal;
  assign drop   = accept && !legal;
  assign pop    = !empty && bus.out_ready;

  assign bus.out_valid = !empty;
  assign bus.out_instr = empty ? 32'd0 : mem_q[rd_ptr_q[PW-2:0]];
  assign bus.out_addr  = addr_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    addr_d    = addr_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    // An address clear wins over the post-pop increment.
    if (bus.addr_clr) addr_d = BASE;
    else if (pop)     addr_d = addr_q + STEP;
    if (drop) begin
      err_d     = 1'b1;
      err_cnt_d = sat_inc(err_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      addr_q    <= BASE;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      addr_q    <= addr_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage is not reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-2:0]] <= encode(bus.in_op, bus.in_rd, bus.in_rs1,
                                                bus.in_rs2, bus.in_imm);
  end
endmodule
